inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Inverse of the pipeline's instruction field decoder: accepts decoded RV32I/A fields plus a full immediate and assembles the 32-bit instruction word.
- Feeds the debug/boot instruction-injection path into the IF stage.
- Encoded words pass through a registered FIFO with valid/ready handshakes on both sides.

Parameters:
DEPTH, 2, output FIFO entries (power of two, >=2)
PTR_W, $clog2(DEPTH), FIFO pointer width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept bundle
in_opcode  in  5  maps to inst[6:2]; inst[1:0] always 2'b11
in_func3  in  3  maps to inst[14:12]
in_func5  in  5  maps to inst[31:27] (AMO only)
in_fun7  in  1  maps to inst[30] (OP; OP-IMM shifts)
in_rs1_index  in  5  maps to inst[19:15]
in_rs2_index  in  5  maps to inst[24:20]
in_rd_index  in  5  maps to inst[11:7]
in_imm  in  32  sign-extended immediate, byte offset for branch/jump
out_valid  out  1  encoded word available
out_ready  in  1  consumer accepts word
out_inst  out  32  encoded instruction
out_illegal  out  1  qualifies out_inst; opcode unsupported or immediate check failed
count  out  PTR_W+1  FIFO occupancy

Behaviour:
- Reset: FIFO empty; count=0; out_valid=0; out_inst=32'h0000_0013 (NOP); out_illegal=0; in_ready=1.
- Handshakes:
  - Input transfer on in_valid&&in_ready. Output transfer on out_valid&&out_ready.
  - in_ready = (count<DEPTH) || out_ready. Full-with-pop accepts in the same cycle.
  - Push and pop in the same cycle: count unchanged, pointers advance, no data loss.
  - in_valid while in_ready=0: bundle ignored. The producer holds it.
  - Empty FIFO: out_valid=0 and out_inst shows the last popped value. It holds after reset.
- Latency: 1 cycle. A word pushed at edge N shows out_valid=1 after edge N.
- Output order is strictly FIFO. out_inst/out_illegal are stable while out_valid&&!out_ready.
- Pointers wrap modulo DEPTH. count spans 0..DEPTH.
- Encoding is combinational before the FIFO write. Common bits: [1:0]=11, [6:2]=opcode.
  - OP 01100 (R): rd, func3, rs1, rs2, [31]=0, [30]=fun7, [29:25]=0.
  - OP-IMM 00100, LOAD 00000, JALR 11001, SYSTEM 11100 (I): rd, func3, rs1, [31:20]=imm[11:0].
    - OP-IMM with func3 001/101 (shift): [31:25]={1'b0,fun7,5'b0}, [24:20]=imm[4:0].
  - STORE 01000 (S): [31:25]=imm[11:5], [11:7]=imm[4:0], func3, rs1, rs2.
  - BRANCH 11000 (B): [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - LUI 01101, AUIPC 00101 (U): rd, [31:12]=imm[31:12].
  - JAL 11011 (J): rd, [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - AMO 01011: R layout with [31:27]=func5, [26:25]=0.
  - Any other opcode: out_inst=NOP (32'h0000_0013), out_illegal=1.
- Reset mid-operation: FIFO contents discarded immediately; outputs return to reset values asynchronously.

Optional Feature:
- Macro: INST_ENC_IMM_CHECK_EN.
- Defined: out_illegal is also set and out_inst forced to NOP when any of these hold:
  - I/S immediate is not in -2048..2047.
  - Shift amount is >31.
  - B immediate is not in -4096..4094 or imm[0]=1.
  - J immediate is not in -2^20..2^20-2 or imm[0]=1.
  - U immediate has imm[11:0]!=0.
- Undefined: immediates are truncated silently. out_illegal reflects the opcode check only.

Decomposition:
- Package inst_enc_pkg holds:
  - opcode localparams (OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM, OPC_AMO)
  - NOP constant 32'h0000_0013
  - format enum (FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD)
- Sub-module inst_enc_fifo: generic DEPTH x 33-bit sync FIFO with async active-low reset. The encode logic stays in the top level.

Test Plan:
- Push OP add (opcode 01100, rd=1, rs1=2, rs2=3, func3=0, fun7=0), out_ready=1 -> out_inst=32'h0031_00B3 one cycle later, out_illegal=0.
- Push BRANCH beq rs1=1, rs2=2, imm=-4 -> 32'hFE20_8EE3. Push JAL rd=1, imm=2048 -> 32'h0010_00EF.
- Push 3 bundles with out_ready=0, DEPTH=2 -> in_ready=0 after 2, count=2. Raise out_ready -> ordered outputs, third bundle accepted in the same cycle as the first pop.
- Push opcode 11111 -> out_inst=32'h0000_0013, out_illegal=1.
- With INST_ENC_IMM_CHECK_EN, push ADDI imm=4096 -> out_illegal=1. Without the macro -> out_inst=32'h0000_0013 (imm truncated to 0), out_illegal=0.
- Assert rst_n low while count=2 mid-stream -> out_valid=0 and count=0 immediately, no further outputs.

Source files
------------

// File: rtl/inst_enc_pkg.sv
// Shared opcode constants, format classification and the NOP word for the
// instruction encoder used on the debug/boot instruction-injection path.
package inst_enc_pkg;

    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;
    localparam logic [4:0] OPC_AMO    = 5'b01011;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } inst_fmt_e;

    function automatic inst_fmt_e fmt_of(input logic [4:0] opc);
        inst_fmt_e f;
        case (opc)
            OPC_OP, OPC_AMO:                                 f = FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM:      f = FMT_I;
            OPC_STORE:                                       f = FMT_S;
            OPC_BRANCH:                                      f = FMT_B;
            OPC_LUI, OPC_AUIPC:                              f = FMT_U;
            OPC_JAL:                                         f = FMT_J;
            default:                                         f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-bundle input and encoded-word output handshakes of the instruction
// encoder; master is the producer/consumer side, slave is the encoder.
interface inst_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [2:0]  in_func3;
    logic [4:0]  in_func5;
    logic        in_fun7;
    logic [4:0]  in_rs1_index;
    logic [4:0]  in_rs2_index;
    logic [4:0]  in_rd_index;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_illegal;

    modport master (
        output in_valid, in_opcode, in_func3, in_func5, in_fun7,
               in_rs1_index, in_rs2_index, in_rd_index, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_illegal
    );

    modport slave (
        input  in_valid, in_opcode, in_func3, in_func5, in_fun7,
               in_rs1_index, in_rs2_index, in_rd_index, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_illegal
    );

endinterface

// File: rtl/inst_enc_fifo.sv
// Generic DEPTH-entry synchronous FIFO; when empty the read port keeps
// presenting the last popped word (RST_DATA after reset).
module inst_enc_fifo #(
    parameter  int                DEPTH    = 2,
    parameter  int                WIDTH    = 33,
    parameter  logic [WIDTH-1:0]  RST_DATA = '0,
    localparam int                PTR_W    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] last_pop;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = empty ? last_pop : mem[rd_ptr];

    // Storage carries no reset; occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_pop <= RST_DATA;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                last_pop <= mem[rd_ptr];
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// Assembles RV32I/A instruction words from decoded fields and queues them.
// Define INST_ENC_IMM_CHECK_EN to flag out-of-range or misaligned immediates.
module inst_encoder
    import inst_enc_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    inst_encoder_if.slave  bus,
    output logic [PTR_W:0] count
);

    inst_fmt_e   fmt;
    logic [31:0] enc_inst;
    logic        enc_illegal;
    logic        imm_bad;
    logic        is_shift;
    logic        fifo_empty;
    logic [32:0] fifo_rd;
    logic        push;
    logic        pop;

    assign fmt      = fmt_of(bus.in_opcode);
    assign is_shift = (bus.in_opcode == OPC_OP_IMM) &&
                      ((bus.in_func3 == 3'b001) || (bus.in_func3 == 3'b101));

`ifdef INST_ENC_IMM_CHECK_EN
    function automatic logic imm_invalid(input inst_fmt_e f, input logic shift,
                                         input logic [31:0] imm);
        logic signed [31:0] s;
        logic               bad;
        s = signed'(imm);
        case (f)
            FMT_I:   bad = shift ? (imm > 32'd31) : ((s < -32'sd2048) || (s > 32'sd2047));
            FMT_S:   bad = (s < -32'sd2048) || (s > 32'sd2047);
            FMT_B:   bad = (s < -32'sd4096) || (s > 32'sd4094) || imm[0];
            FMT_J:   bad = (s < -32'sd1048576) || (s > 32'sd1048574) || imm[0];
            FMT_U:   bad = (imm[11:0] != 12'h000);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    assign imm_bad = imm_invalid(fmt, is_shift, bus.in_imm);
`else
    assign imm_bad = 1'b0;
`endif

    always_comb begin
        enc_inst    = INST_NOP;
        enc_illegal = 1'b0;
        case (fmt)
            FMT_R: begin
                if (bus.in_opcode == OPC_AMO) begin
                    enc_inst = {bus.in_func5, 2'b00, bus.in_rs2_index, bus.in_rs1_index,
                                bus.in_func3, bus.in_rd_index, bus.in_opcode, 2'b11};
                end else begin
                    enc_inst = {1'b0, bus.in_fun7, 5'b0, bus.in_rs2_index, bus.in_rs1_index,
                                bus.in_func3, bus.in_rd_index, bus.in_opcode, 2'b11};
                end
            end
            FMT_I: begin
                if (is_shift) begin
                    enc_inst = {1'b0, bus.in_fun7, 5'b0, bus.in_imm[4:0], bus.in_rs1_index,
                                bus.in_func3, bus.in_rd_index, bus.in_opcode, 2'b11};
                end else begin
                    enc_inst = {bus.in_imm[11:0], bus.in_rs1_index,
                                bus.in_func3, bus.in_rd_index, bus.in_opcode, 2'b11};
                end
            end
            FMT_S: enc_inst = {bus.in_imm[11:5], bus.in_rs2_index, bus.in_rs1_index,
                               bus.in_func3, bus.in_imm[4:0], bus.in_opcode, 2'b11};
            FMT_B: enc_inst = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2_index,
                               bus.in_rs1_index, bus.in_func3, bus.in_imm[4:1],
                               bus.in_imm[11], bus.in_opcode, 2'b11};
            FMT_U: enc_inst = {bus.in_imm[31:12], bus.in_rd_index, bus.in_opcode, 2'b11};
            FMT_J: enc_inst = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                               bus.in_imm[19:12], bus.in_rd_index, bus.in_opcode, 2'b11};
            default: enc_illegal = 1'b1;
        endcase
        // Any rejected bundle is replaced by a harmless NOP so IF never sees junk.
        if (enc_illegal || imm_bad) begin
            enc_inst    = INST_NOP;
            enc_illegal = 1'b1;
        end
    end

    assign bus.in_ready    = (count < (PTR_W+1)'(DEPTH)) || bus.out_ready;
    assign bus.out_valid   = !fifo_empty;
    assign bus.out_inst    = fifo_rd[31:0];
    assign bus.out_illegal = fifo_rd[32];
    assign push            = bus.in_valid && bus.in_ready;
    assign pop             = bus.out_valid && bus.out_ready;

    inst_enc_fifo #(
        .DEPTH    (DEPTH),
        .WIDTH    (33),
        .RST_DATA ({1'b0, INST_NOP})
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({enc_illegal, enc_inst}),
        .pop       (pop),
        .rd_data   (fifo_rd),
        .empty     (fifo_empty),
        .count     (count)
    );

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: encodings, FIFO back-pressure and async reset.
module tb_inst_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] count;
    int         n_chk  = 0;
    int         n_pass = 0;

    inst_encoder_if bus();

    inst_encoder #(.DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] opc, input logic [2:0] f3, input logic [4:0] f5,
                         input logic f7, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] imm);
        bus.in_opcode    = opc;
        bus.in_func3     = f3;
        bus.in_func5     = f5;
        bus.in_fun7      = f7;
        bus.in_rs1_index = rs1;
        bus.in_rs2_index = rs2;
        bus.in_rd_index  = rd;
        bus.in_imm       = imm;
        bus.in_valid     = 1'b1;
    endtask

    // Push one bundle with the consumer ready, check the word, then its pop.
    task automatic send_one(input string tag, input logic [31:0] exp_inst, input logic exp_ill);
        bus.out_ready = 1'b1;
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".inst"}, bus.out_inst, exp_inst);
        chk({tag, ".illegal"}, 32'(bus.out_illegal), 32'(exp_ill));
        step();
        chk({tag, ".drained"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".held"}, bus.out_inst, exp_inst);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(5'b0, 3'b0, 5'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        bus.in_valid  = 1'b0;
        #12;
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.out_inst", bus.out_inst, 32'h0000_0013);
        chk("rst.out_illegal", 32'(bus.out_illegal), 32'd0);
        chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        step();

        drive(5'b01100, 3'b000, 5'd0, 1'b0, 5'd2, 5'd3, 5'd1, 32'd0);
        send_one("add", 32'h0031_00B3, 1'b0);
        drive(5'b11000, 3'b000, 5'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC);
        send_one("beq", 32'hFE20_8EE3, 1'b0);
        drive(5'b11011, 3'b000, 5'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd2048);
        send_one("jal", 32'h0010_00EF, 1'b0);
        drive(5'b01000, 3'b010, 5'd0, 1'b0, 5'd6, 5'd5, 5'd0, 32'hFFFF_FFF8);
        send_one("sw", 32'hFE53_2C23, 1'b0);
        drive(5'b01101, 3'b000, 5'd0, 1'b0, 5'd0, 5'd0, 5'd5, 32'h1234_5000);
        send_one("lui", 32'h1234_52B7, 1'b0);
        drive(5'b00100, 3'b101, 5'd0, 1'b1, 5'd2, 5'd0, 5'd1, 32'd3);
        send_one("srai", 32'h4031_5093, 1'b0);
        drive(5'b01011, 3'b010, 5'b00001, 1'b0, 5'd2, 5'd3, 5'd1, 32'd0);
        send_one("amoswap", 32'h0831_20AF, 1'b0);
        drive(5'b11111, 3'b000, 5'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0);
        send_one("badopc", 32'h0000_0013, 1'b1);
        drive(5'b00100, 3'b000, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd4096);
`ifdef INST_ENC_IMM_CHECK_EN
        send_one("addi4096", 32'h0000_0013, 1'b1);
`else
        send_one("addi4096", 32'h0000_0013, 1'b0);
`endif

        // Back-pressure: two words fill the FIFO, the third waits for a pop.
        bus.out_ready = 1'b0;
        drive(5'b01100, 3'b000, 5'd0, 1'b0, 5'd2, 5'd3, 5'd1, 32'd0);
        step();
        chk("bp.count1", 32'(count), 32'd1);
        drive(5'b01101, 3'b000, 5'd0, 1'b0, 5'd0, 5'd0, 5'd5, 32'h1234_5000);
        step();
        chk("bp.count2", 32'(count), 32'd2);
        chk("bp.in_ready_full", 32'(bus.in_ready), 32'd0);
        chk("bp.head", bus.out_inst, 32'h0031_00B3);
        drive(5'b01000, 3'b010, 5'd0, 1'b0, 5'd6, 5'd5, 5'd0, 32'hFFFF_FFF8);
        step();
        chk("bp.ignored_count", 32'(count), 32'd2);
        chk("bp.stable_head", bus.out_inst, 32'h0031_00B3);
        bus.out_ready = 1'b1;
        #1;
        chk("bp.in_ready_pop", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("bp.count_pushpop", 32'(count), 32'd2);
        chk("bp.second", bus.out_inst, 32'h1234_52B7);
        step();
        chk("bp.count_after2", 32'(count), 32'd1);
        chk("bp.third", bus.out_inst, 32'hFE53_2C23);
        step();
        chk("bp.empty_valid", 32'(bus.out_valid), 32'd0);
        chk("bp.empty_count", 32'(count), 32'd0);
        chk("bp.last_popped", bus.out_inst, 32'hFE53_2C23);

        // Asynchronous reset with a full FIFO.
        bus.out_ready = 1'b0;
        drive(5'b11011, 3'b000, 5'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd2048);
        step();
        step();
        bus.in_valid = 1'b0;
        chk("mid.count_full", 32'(count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid.out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid.count", 32'(count), 32'd0);
        chk("mid.out_inst", bus.out_inst, 32'h0000_0013);
        chk("mid.in_ready", 32'(bus.in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid.no_output", 32'(bus.out_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
